// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between ALU and load writebacks
// and keeps the per-register pending-write scoreboard used for hazard checks.
module rf_wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        iss_valid,
    input  logic [4:0]  iss_reg,
    output logic        iss_ready,
    input  logic [4:0]  chk_reg1,
    input  logic [4:0]  chk_reg2,
    output logic        hazard,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        m_valid,
    input  logic [4:0]  m_reg,
    input  logic [31:0] m_data,
    output logic        m_ready,
    output logic        RegWr,
    output logic [4:0]  W_Reg,
    output logic [31:0] W_data,
    output logic [31:0] pending
);
    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;

    logic        r_last_grant;
    logic        r_regwr_p1;
    logic [4:0]  r_wreg_p1;
    logic [31:0] r_wdata_p1;
    logic [31:0] r_pending;

    logic        w_a_grant;
    logic        w_m_grant;
    logic        w_iss_acc;
    logic [31:0] w_set;
    logic [31:0] w_clr;

    // On a tie the requester that did not win last time is granted.
    assign w_a_grant = rst_n & a_valid & (~m_valid | (r_last_grant == GRANT_LD));
    assign w_m_grant = rst_n & m_valid & (~a_valid | (r_last_grant == GRANT_ALU));
    assign a_ready   = w_a_grant;
    assign m_ready   = w_m_grant;

    assign iss_ready = rst_n & ((iss_reg == 5'd0) | ~r_pending[iss_reg]);
    assign w_iss_acc = iss_valid & iss_ready & (iss_reg != 5'd0);
    assign w_set     = w_iss_acc ? (32'd1 << iss_reg) : 32'd0;
    assign w_clr     = r_regwr_p1 ? (32'd1 << r_wreg_p1) : 32'd0;

    assign hazard = rst_n & (((chk_reg1 != 5'd0) & r_pending[chk_reg1]) |
                             ((chk_reg2 != 5'd0) & r_pending[chk_reg2]));

    // Stage p0 -> p1: register the granted writeback onto the RF write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_LD;
            r_regwr_p1   <= 1'b0;
            r_wreg_p1    <= 5'd0;
            r_wdata_p1   <= 32'd0;
        end else if (w_a_grant) begin
            r_last_grant <= GRANT_ALU;
            r_regwr_p1   <= (a_reg != 5'd0);
            r_wreg_p1    <= a_reg;
            r_wdata_p1   <= a_data;
        end else if (w_m_grant) begin
            r_last_grant <= GRANT_LD;
            r_regwr_p1   <= (m_reg != 5'd0);
            r_wreg_p1    <= m_reg;
            r_wdata_p1   <= m_data;
        end else begin
            r_regwr_p1   <= 1'b0;
        end
    end

    // Clear lands with the RF write; a coincident set takes precedence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 32'd0;
        end else begin
            r_pending <= ((r_pending & ~w_clr) | w_set) & ~32'd1;
        end
    end

    assign RegWr   = r_regwr_p1;
    assign W_Reg   = r_wreg_p1;
    assign W_data  = r_wdata_p1;
    assign pending = r_pending;
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- iss_valid  in  1  decode announces an in-flight destination register.
- iss_reg  in  5  destination register index being issued.
- iss_ready  out  1  issue accepted this cycle.
- chk_reg1, chk_reg2  in  5 each  source registers of the instruction in decode.
- hazard  out  1  a source register has a write pending.
- a_valid  in  1  ALU writeback request.
- a_reg  in  5  ALU writeback destination.
- a_data  in  32  ALU writeback data.
- a_ready  out  1  ALU request granted.
- m_valid  in  1  load writeback request.
- m_reg  in  5  load writeback destination.
- m_data  in  32  load writeback data.
- m_ready  out  1  load request granted.
- RegWr  out  1  RF write enable.
- W_Reg  out  5  RF write index.
- W_data  out  32  RF write data.
- pending  out  32  scoreboard; bit i = register i awaiting writeback.

Function
REQ-003 The block SHALL share the single RF write port between the ALU and load requesters; a transfer occurs in a cycle where valid and ready are both 1.
REQ-004 a_ready and m_ready SHALL be combinational; at most one SHALL be 1 per cycle.
REQ-005 Arbitration: only one requester valid -> it is granted; both valid -> the requester not granted most recently wins (round-robin via a 1-bit last_grant register, updated only on a grant).
REQ-006 A requester SHALL hold valid, reg and data stable until granted; the block does not buffer ungranted requests.
REQ-007 The write port SHALL be registered: grant in cycle N -> RegWr, W_Reg, W_data driven in cycle N+1, so the RF captures the data at the end of cycle N+1.
REQ-008 A grant to register 0 SHALL complete the handshake but drive RegWr=0 in N+1; W_Reg and W_data still update.
REQ-009 No grant in cycle N -> RegWr=0 in N+1; W_Reg and W_data hold their previous values.
REQ-010 Issue: iss_ready = rst_n & (iss_reg==0 | ~pending[iss_reg]); a stall on a pending destination is a WAW stall.
REQ-011 An accepted issue with iss_reg!=0 SHALL set pending[iss_reg] at the end of that cycle; issue to register 0 SHALL never set a bit.
REQ-012 pending[W_Reg] SHALL clear at the end of any cycle where RegWr=1, coinciding with the RF write, so hazard covers the whole in-flight window.
REQ-013 A set and a clear of the same bit in one cycle cannot arise legally (per REQ-010); if it does occur, the set SHALL win.
REQ-014 A write to a register whose pending bit is 0 SHALL proceed normally; the pending register is unaffected.
REQ-015 hazard = rst_n & ((chk_reg1!=0 & pending[chk_reg1]) | (chk_reg2!=0 & pending[chk_reg2])), purely combinational; there is no bypass, and the same-cycle RF write does not suppress hazard.
REQ-016 pending[0] SHALL always read 0.

Reset
REQ-017 While rst_n=0 at a posedge, the block SHALL set pending=0, RegWr=0, W_Reg=0, W_data=0 and last_grant=load, so the ALU wins the first tie.
REQ-018 While rst_n=0: a_ready, m_ready, iss_ready and hazard SHALL be 0, and no transfer or issue occurs.
REQ-019 Reset mid-operation SHALL discard any grant from the same cycle; RegWr=0 in the following cycle.

Verification
REQ-020 Reset, then iss_valid=1, iss_reg=5 -> iss_ready=1; next cycle pending=0x00000020; chk_reg1=5 -> hazard=1.
REQ-021 With pending[5]=1: a_valid=1, a_reg=5, a_data=0xDEADBEEF in cycle N -> a_ready=1 in N; RegWr=1, W_Reg=5, W_data=0xDEADBEEF in N+1; pending[5]=0 and hazard=0 in N+2.
REQ-022 a_valid and m_valid held at 1 for 4 cycles after reset -> grants A, M, A, M; RegWr=1 in each of the next 4 cycles.
REQ-023 With pending[7]=1: iss_valid=1, iss_reg=7 -> iss_ready=0 and pending unchanged; iss_reg=0 -> iss_ready=1 and pending unchanged.
REQ-024 m_valid=1, m_reg=0 -> m_ready=1; RegWr=0 next cycle. rst_n=0 asserted in the same cycle as a grant -> RegWr=0 and pending=0 next cycle.
